io_handshake_unit: RTL and testbench

IO_HANDSHAKE_UNIT -- requirements
Module: io_handshake_unit

---
 rtl/io_handshake_unit.sv | 176 +++++++++++++++++
 tb/tb_io_handshake_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_unit.sv
// io_handshake_unit: processor-side I/O handshakes for a switch/enter-button
// input path and a 32-bit display output path.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   in_req          processor asks for an input word (held until consumed)
//   in_ready        input word valid on in_data (held until in_req falls)
//   in_data         captured input word {16'b0, sw}
//   sw              raw switch value, sampled only on an accepted press
//   btn_enter       raw asynchronous enter button, active-high
//   waiting_input   request pending, no press accepted yet (LED)
//   new_out         processor asks to display out_data (held until out_done)
//   out_data        word to display
//   out_done        output accepted (held until new_out falls)
//   display         last accepted output word
module io_handshake_unit #(
  parameter logic [19:0] DEB_CYCLES = 20'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req,
  output logic        in_ready,
  output logic [31:0] in_data,
  input  logic [15:0] sw,
  input  logic        btn_enter,
  output logic        waiting_input,
  input  logic        new_out,
  input  logic [31:0] out_data,
  output logic        out_done,
  output logic [31:0] display
);

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SW_W   = 16;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_WAIT = 2'd1,
    I_ACK  = 2'd2
  } in_state_t;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_ACK  = 1'b1
  } out_state_t;

  logic             btn_s1;
  logic             btn_s2;
  logic [CNT_W-1:0] deb_cnt;
  logic             press;

  in_state_t         in_state;
  in_state_t         in_state_d;
  logic              in_ready_d;
  logic              waiting_d;
  logic [DATA_W-1:0] in_data_d;

  out_state_t        out_state;
  out_state_t        out_state_d;
  logic              out_done_d;
  logic [DATA_W-1:0] display_d;

  // Button synchronizer, saturating debounce counter and press pulse.
  // The pulse is raised in the cycle the counter reaches DEB_CYCLES; since
  // the counter then sits saturated, a new pulse needs the button to drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      btn_s1 <= btn_enter;
      btn_s2 <= btn_s1;
      press  <= btn_s2 && (deb_cnt != DEB_CYCLES) &&
                (deb_cnt == DEB_CYCLES - CNT_W'(1));
      if (!btn_s2) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_CYCLES) begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  // Input FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state      <= I_IDLE;
      in_ready      <= 1'b0;
      waiting_input <= 1'b0;
      in_data       <= '0;
    end else begin
      in_state      <= in_state_d;
      in_ready      <= in_ready_d;
      waiting_input <= waiting_d;
      in_data       <= in_data_d;
    end
  end

  // Input FSM next state; an abort (in_req low) beats a coincident press.
  always_comb begin
    in_state_d = I_IDLE;
    in_ready_d = 1'b0;
    waiting_d  = 1'b0;
    in_data_d  = in_data;
    case (in_state)
      I_IDLE: begin
        if (in_req) begin
          in_state_d = I_WAIT;
          waiting_d  = 1'b1;
        end
      end
      I_WAIT: begin
        if (!in_req) begin
          in_state_d = I_IDLE;
        end else if (press) begin
          in_state_d = I_ACK;
          in_ready_d = 1'b1;
          in_data_d  = {(DATA_W - SW_W)'(0), sw};
        end else begin
          in_state_d = I_WAIT;
          waiting_d  = 1'b1;
        end
      end
      I_ACK: begin
        if (in_req) begin
          in_state_d = I_ACK;
          in_ready_d = 1'b1;
        end
      end
      default: begin
        in_data_d = '0;
      end
    endcase
  end

  // Output FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state <= O_IDLE;
      out_done  <= 1'b0;
      display   <= '0;
    end else begin
      out_state <= out_state_d;
      out_done  <= out_done_d;
      display   <= display_d;
    end
  end

  // Output FSM next state; display is frozen while acknowledging.
  always_comb begin
    out_state_d = O_IDLE;
    out_done_d  = 1'b0;
    display_d   = display;
    case (out_state)
      O_IDLE: begin
        if (new_out) begin
          out_state_d = O_ACK;
          out_done_d  = 1'b1;
          display_d   = out_data;
        end
      end
      O_ACK: begin
        if (new_out) begin
          out_state_d = O_ACK;
          out_done_d  = 1'b1;
        end
      end
      default: begin
        display_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_io_handshake_unit.sv
module tb_io_handshake_unit;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_req = 1'b0;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] sw = '0;
  logic        btn_enter = 1'b0;
  logic        waiting_input;
  logic        new_out = 1'b0;
  logic [31:0] out_data = '0;
  logic        out_done;
  logic [31:0] display;

  int compared = 0;
  int mismatched = 0;

  io_handshake_unit #(.DEB_CYCLES(20'd4)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_ready(in_ready),
    .in_data(in_data), .sw(sw), .btn_enter(btn_enter),
    .waiting_input(waiting_input), .new_out(new_out), .out_data(out_data),
    .out_done(out_done), .display(display)
  );

  always #5 clk = ~clk;

  logic [66:0] obs;
  assign obs = {in_ready, waiting_input, out_done, in_data, display};

  // Reference model: button run length on raw samples; a run reaching DEB is
  // a press that the handshake acts on three edges later (2 sync + 1 pulse).
  int          run;
  bit  [2:0]   pipe;
  bit          m_wait, m_ready, m_done;
  logic [31:0] m_data, m_disp;
  logic [66:0] mdl;

  function automatic void model_reset();
    run = 0; pipe = '0;
    m_wait = 0; m_ready = 0; m_done = 0;
    m_data = '0; m_disp = '0;
    mdl = '0;
  endfunction

  function automatic void model_edge();
    bit pr;
    pr   = pipe[2];
    run  = btn_enter ? ((run < 1000) ? run + 1 : run) : 0;
    pipe = {pipe[1:0], (run == DEB)};
    if (m_ready) begin
      if (!in_req) m_ready = 0;
    end else if (m_wait) begin
      if (!in_req) m_wait = 0;
      else if (pr) begin
        m_data = {16'h0, sw}; m_ready = 1; m_wait = 0;
      end
    end else if (in_req) begin
      m_wait = 1;
    end
    if (m_done) begin
      if (!new_out) m_done = 0;
    end else if (new_out) begin
      m_disp = out_data; m_done = 1;
    end
    mdl = {m_ready, m_wait, m_done, m_data, m_disp};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compared++;
    if (obs !== 67'h0) begin
      mismatched++;
      $display("FAIL reset_state: got %h expected %h", obs, 67'h0);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_input();
    do_reset();
    sw = 16'hA5C3; in_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      btn_enter = (i >= 1 && i < 9);
      step();
      compared++;
      if (obs !== mdl) begin
        mismatched++;
        $display("FAIL input cyc %0d: got %h expected %h", i, obs, mdl);
      end
    end
    compared++;
    if ({in_ready, waiting_input, in_data} !== {1'b1, 1'b0, 32'h0000A5C3}) begin
      mismatched++;
      $display("FAIL input_capture: got rdy=%b wait=%b data=%h expected 1 0 0000a5c3",
               in_ready, waiting_input, in_data);
    end
    in_req = 1'b0;
    step();
    compared++;
    if (in_ready !== 1'b0 || obs !== mdl) begin
      mismatched++;
      $display("FAIL input_release: got %h expected %h", obs, mdl);
    end
  endtask

  task automatic test_bounce();
    bit pat [0:20];
    do_reset();
    sw = 16'h1357; in_req = 1'b1;
    for (int i = 0; i < 21; i++) pat[i] = (i < 3) || (i >= 4 && i < 7) || (i >= 12 && i < 17);
    for (int i = 0; i < 21; i++) begin
      btn_enter = pat[i];
      step();
      compared++;
      if (obs !== mdl) begin
        mismatched++;
        $display("FAIL bounce cyc %0d: got %h expected %h", i, obs, mdl);
      end
      if (i == 11) begin
        compared++;
        if (in_ready !== 1'b0 || waiting_input !== 1'b1) begin
          mismatched++;
          $display("FAIL bounce_reject: got rdy=%b wait=%b expected 0 1", in_ready, waiting_input);
        end
      end
    end
    compared++;
    if (in_ready !== 1'b1 || in_data !== 32'h00001357) begin
      mismatched++;
      $display("FAIL bounce_accept: got rdy=%b data=%h expected 1 00001357", in_ready, in_data);
    end
    in_req = 1'b0; btn_enter = 1'b0;
    step();
  endtask

  task automatic test_output();
    do_reset();
    new_out = 1'b1; out_data = 32'hDEADBEEF;
    step();
    compared++;
    if ({out_done, display} !== {1'b1, 32'hDEADBEEF} || obs !== mdl) begin
      mismatched++;
      $display("FAIL output_accept: got done=%b disp=%h expected 1 deadbeef", out_done, display);
    end
    out_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if ({out_done, display} !== {1'b1, 32'hDEADBEEF} || obs !== mdl) begin
        mismatched++;
        $display("FAIL output_hold cyc %0d: got done=%b disp=%h expected 1 deadbeef", i, out_done, display);
      end
    end
    new_out = 1'b0;
    step();
    compared++;
    if ({out_done, display} !== {1'b0, 32'hDEADBEEF}) begin
      mismatched++;
      $display("FAIL output_release: got done=%b disp=%h expected 0 deadbeef", out_done, display);
    end
  endtask

  task automatic test_abort();
    do_reset();
    sw = 16'hFFFF; in_req = 1'b1;
    step(); step();
    in_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn_enter = (i >= 1 && i < 9);
      step();
      compared++;
      if (obs !== mdl) begin
        mismatched++;
        $display("FAIL abort cyc %0d: got %h expected %h", i, obs, mdl);
      end
    end
    compared++;
    if ({in_ready, waiting_input, in_data} !== 34'h0) begin
      mismatched++;
      $display("FAIL abort_nocapture: got rdy=%b wait=%b data=%h expected 0 0 0",
               in_ready, waiting_input, in_data);
    end
  endtask

  task automatic test_concurrent_reset();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      sw = 16'h0BAD; out_data = 32'h12345678;
      in_req = 1'b1; new_out = 1'b1;
      for (int i = 0; i < 9; i++) begin
        btn_enter = (i < 8);
        step();
        compared++;
        if (obs !== mdl) begin
          mismatched++;
          $display("FAIL concur p%0d cyc %0d: got %h expected %h", pass, i, obs, mdl);
        end
      end
      compared++;
      if (obs !== {3'b101, 32'h00000BAD, 32'h12345678}) begin
        mismatched++;
        $display("FAIL concur_both p%0d: got %h expected %h", pass, obs,
                 {3'b101, 32'h00000BAD, 32'h12345678});
      end
      if (pass == 0) begin
        in_req = 1'b0; new_out = 1'b0;
        step();
        compared++;
        if ({in_ready, out_done} !== 2'b00) begin
          mismatched++;
          $display("FAIL concur_release: got rdy=%b done=%b expected 0 0", in_ready, out_done);
        end
      end else begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        compared++;
        if (obs !== 67'h0) begin
          mismatched++;
          $display("FAIL reset_in_ack: got %h expected 0", obs);
        end
        in_req = 1'b0; new_out = 1'b0; btn_enter = 1'b0;
        step();
        rst = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    int errs_here;
    errs_here = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) in_req = ~in_req;
      if ($urandom_range(5) == 0) btn_enter = ~btn_enter;
      if ($urandom_range(3) == 0) new_out = ~new_out;
      sw = 16'($urandom);
      out_data = $urandom;
      if ($urandom_range(299) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        compared++;
        if (obs !== 67'h0) begin
          mismatched++;
          $display("FAIL random_reset cyc %0d: got %h expected 0", i, obs);
        end
        step();
        rst = 1'b0;
      end else begin
        step();
        compared++;
        if (obs !== mdl) begin
          mismatched++;
          errs_here++;
          if (errs_here <= 10)
            $display("FAIL random cyc %0d: got %h expected %h", i, obs, mdl);
        end
      end
    end
    in_req = 1'b0; new_out = 1'b0; btn_enter = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_input();
    test_bounce();
    test_output();
    test_abort();
    test_concurrent_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
